// File: rtl/idu_buffered_pkg.sv
// Shared types and constants for the buffered instruction decode unit.
// Field positions follow the base RISC-V encoding.
package idu_buffered_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;
    localparam int RD_LSB    = 7;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } q_entry_t;

    function automatic logic [4:0] rs1_of(input logic [31:0] inst);
        return inst[RS1_LSB +: 5];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] inst);
        return inst[RS2_LSB +: 5];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] inst);
        return inst[RD_LSB +: 5];
    endfunction

endpackage

// File: rtl/idu_buffered_inst_queue.sv
// Circular instruction FIFO feeding the decode output register.
// Flush and reset both empty it in one cycle.
module inst_queue
    import idu_buffered_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  q_entry_t               push_entry,
    output q_entry_t               head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    q_entry_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/idu_buffered.sv
// Buffered decode stage: fetch queue, register file, load-use interlock
// and the registered decode-stage output.
module idu_buffered
    import idu_buffered_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_ex_load,
    input  logic [4:0]  i_ex_rd_addr,
    input  logic        i_rd_wr,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_rd_data,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    output logic        o_hazard
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [31:0]   rf [32];
    q_entry_t      head;
    q_entry_t      in_entry;
    q_entry_t      cand;
    logic [CW-1:0] q_count;
    logic          q_empty;
    logic          q_push;
    logic          q_pop;
    logic          accept;
    logic          adv;
    logic          cand_avail;
    logic          hazard;
    logic          load;
    logic [4:0]    c_rs1;
    logic [4:0]    c_rs2;
    logic [31:0]   rs1_val;
    logic [31:0]   rs2_val;

    assign q_empty  = (q_count == '0);
    assign o_ready  = (q_count != FULL_C) && !rst;
    assign accept   = i_valid && o_ready && !i_flush;
    assign adv      = !o_valid || !i_stall;
    assign in_entry = '{pc: i_pc, inst: i_inst};

    // An empty queue lets the incoming word compete for the output directly.
    assign cand       = q_empty ? in_entry : head;
    assign cand_avail = !q_empty || accept;
    assign c_rs1      = rs1_of(cand.inst);
    assign c_rs2      = rs2_of(cand.inst);

    assign hazard = cand_avail && i_ex_load && (i_ex_rd_addr != 5'd0) &&
                    ((i_ex_rd_addr == c_rs1) || (i_ex_rd_addr == c_rs2));
    assign o_hazard = hazard && !rst;

    assign load   = adv && cand_avail && !hazard && !i_flush;
    assign q_pop  = load && !q_empty;
    assign q_push = accept && !(load && q_empty);

    inst_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (i_flush),
        .push_entry(in_entry),
        .head      (head),
        .count     (q_count)
    );

    always_comb begin
        rs1_val = rf[c_rs1];
        rs2_val = rf[c_rs2];
        if (BYPASS && i_rd_wr && (i_rd_addr == c_rs1)) rs1_val = i_rd_data;
        if (BYPASS && i_rd_wr && (i_rd_addr == c_rs2)) rs2_val = i_rd_data;
        if (c_rs1 == 5'd0) rs1_val = '0;
        if (c_rs2 == 5'd0) rs2_val = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (i_rd_wr && (i_rd_addr != 5'd0)) begin
            rf[i_rd_addr] <= i_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_pc       <= '0;
            o_inst     <= '0;
            o_rs1_data <= '0;
            o_rs2_data <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (adv) begin
            o_valid <= load;
            if (load) begin
                o_pc       <= cand.pc;
                o_inst     <= cand.inst;
                o_rs1_data <= rs1_val;
                o_rs2_data <= rs2_val;
            end
        end else begin
            // A held instruction keeps tracking writebacks to its sources.
            if (i_rd_wr && (i_rd_addr != 5'd0) && (i_rd_addr == o_rs1_addr))
                o_rs1_data <= i_rd_data;
            if (i_rd_wr && (i_rd_addr != 5'd0) && (i_rd_addr == o_rs2_addr))
                o_rs2_data <= i_rd_data;
        end
    end

    assign o_rs1_addr = rs1_of(o_inst);
    assign o_rs2_addr = rs2_of(o_inst);
    assign o_rd_addr  = rd_of(o_inst);

endmodule

// File: tb/tb_idu_buffered.sv
// Scoreboard bench for idu_buffered: directed scenarios followed by
// randomized traffic against an in-order architectural model.
module tb_idu_buffered;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] i_pc, i_inst, i_rd_data;
    logic        i_valid, i_flush, i_stall, i_ex_load, i_rd_wr;
    logic [4:0]  i_ex_rd_addr, i_rd_addr;

    logic        o_ready, o_valid, o_hazard;
    logic [31:0] o_pc, o_inst, o_rs1_data, o_rs2_data;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;

    logic        nb_ready, nb_valid, nb_hazard;
    logic [31:0] nb_pc, nb_inst, nb_rs1_data, nb_rs2_data;
    logic [4:0]  nb_rs1_addr, nb_rs2_addr, nb_rd_addr;

    idu_buffered #(.DEPTH(DEPTH), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .i_pc(i_pc), .i_inst(i_inst),
        .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
        .i_stall(i_stall), .i_ex_load(i_ex_load),
        .i_ex_rd_addr(i_ex_rd_addr), .i_rd_wr(i_rd_wr),
        .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
        .o_valid(o_valid), .o_pc(o_pc), .o_inst(o_inst),
        .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .o_rd_addr(o_rd_addr), .o_rs1_data(o_rs1_data),
        .o_rs2_data(o_rs2_data), .o_hazard(o_hazard)
    );

    idu_buffered #(.DEPTH(DEPTH), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .i_pc(i_pc), .i_inst(i_inst),
        .i_valid(i_valid), .o_ready(nb_ready), .i_flush(i_flush),
        .i_stall(i_stall), .i_ex_load(i_ex_load),
        .i_ex_rd_addr(i_ex_rd_addr), .i_rd_wr(i_rd_wr),
        .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
        .o_valid(nb_valid), .o_pc(nb_pc), .o_inst(nb_inst),
        .o_rs1_addr(nb_rs1_addr), .o_rs2_addr(nb_rs2_addr),
        .o_rd_addr(nb_rd_addr), .o_rs1_data(nb_rs1_data),
        .o_rs2_data(nb_rs2_data), .o_hazard(nb_hazard)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } word_t;

    int          checks = 0;
    int          errors = 0;
    word_t       exp_q[$];
    logic [31:0] arch_rf [32];
    bit          armed = 1'b0;
    logic        prev_adv = 1'b0;
    logic        prev_kill = 1'b1;
    logic        prev_ex_load = 1'b0;
    logic [4:0]  prev_ex_rd = 5'd0;
    logic        hz;
    word_t       w;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor and reference model; inputs are stable from posedge+1 onward.
    always @(negedge clk) begin
        if (armed) begin
            if (o_valid && prev_adv && !prev_kill) begin
                hz = prev_ex_load && (prev_ex_rd != 5'd0) &&
                     ((prev_ex_rd == o_inst[19:15]) ||
                      (prev_ex_rd == o_inst[24:20]));
                check("issue_without_hazard", 32'(hz), 32'd0);
            end
            if (o_valid && !i_stall) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got pc %h, expected none",
                             o_pc);
                end else begin
                    w = exp_q.pop_front();
                    check("pc", o_pc, w.pc);
                    check("inst", o_inst, w.inst);
                    check("rd_addr", 32'(o_rd_addr), 32'(w.inst[11:7]));
                    check("rs1_addr", 32'(o_rs1_addr), 32'(w.inst[19:15]));
                    check("rs2_addr", 32'(o_rs2_addr), 32'(w.inst[24:20]));
                    check("rs1_data", o_rs1_data, arch_rf[w.inst[19:15]]);
                    check("rs2_data", o_rs2_data, arch_rf[w.inst[24:20]]);
                    check("nb_valid", 32'(nb_valid), 32'd1);
                    check("nb_pc", nb_pc, w.pc);
                end
            end
        end
        prev_adv     = !o_valid || !i_stall;
        prev_kill    = i_flush || rst;
        prev_ex_load = i_ex_load;
        prev_ex_rd   = i_ex_rd_addr;
        if (rst) begin
            armed = 1'b1;
            exp_q.delete();
            for (int i = 0; i < 32; i++) arch_rf[i] = 32'd0;
        end else begin
            if (i_flush) exp_q.delete();
            else if (i_valid && o_ready) exp_q.push_back('{pc: i_pc, inst: i_inst});
            if (i_rd_wr && (i_rd_addr != 5'd0)) arch_rf[i_rd_addr] = i_rd_data;
        end
    end

    task automatic idle();
        i_valid = 0; i_flush = 0; i_stall = 0; i_ex_load = 0;
        i_ex_rd_addr = 0; i_rd_wr = 0; i_rd_addr = 0; i_rd_data = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        i_valid = 1; i_pc = pc; i_inst = inst;
    endtask

    logic [31:0] ins;
    logic [31:0] pc_ctr;

    initial begin
        rst = 1; idle(); i_pc = 0; i_inst = 0;
        cyc(); cyc();
        @(negedge clk);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_hazard", 32'(o_hazard), 32'd0);
        check("rst_pc", o_pc, 32'd0);
        check("rst_rs1_data", o_rs1_data, 32'd0);

        // first word straight into the output register
        cyc(); rst = 0; push(32'h0, 32'h0050_0093);
        @(negedge clk);
        check("ready_after_rst", 32'(o_ready), 32'd1);
        check("valid_before_load", 32'(o_valid), 32'd0);
        cyc(); idle();
        @(negedge clk);
        check("first_valid", 32'(o_valid), 32'd1);
        check("first_pc", o_pc, 32'h0);
        check("first_rd", 32'(o_rd_addr), 32'd1);

        // fill under stall
        for (int k = 0; k < DEPTH + 2; k++) begin
            cyc(); i_stall = 1;
            push(32'h100 + 32'(4 * k), 32'h13 | (32'(k) << 7));
            @(negedge clk);
            check("fill_ready", 32'(o_ready), (k <= DEPTH) ? 32'd1 : 32'd0);
        end
        cyc(); idle();
        for (int k = 0; k <= DEPTH; k++) begin
            @(negedge clk);
            check("drain_valid", 32'(o_valid), 32'd1);
            check("drain_pc", o_pc, 32'h100 + 32'(4 * k));
            cyc();
        end
        @(negedge clk);
        check("overflow_dropped", 32'(o_valid), 32'd0);

        // load-use interlock
        cyc(); i_ex_load = 1; i_ex_rd_addr = 5; push(32'h200, 32'h0002_8013);
        @(negedge clk);
        check("hazard_bypass_cand", 32'(o_hazard), 32'd1);
        cyc(); i_valid = 0;
        @(negedge clk);
        check("hazard_head", 32'(o_hazard), 32'd1);
        check("hazard_bubble", 32'(o_valid), 32'd0);
        cyc(); i_ex_load = 0;
        @(negedge clk);
        check("hazard_clear", 32'(o_hazard), 32'd0);
        check("hazard_still_bubble", 32'(o_valid), 32'd0);
        cyc(); i_ex_load = 1; i_ex_rd_addr = 0; push(32'h204, 32'h13);
        @(negedge clk);
        check("hazard_issue_valid", 32'(o_valid), 32'd1);
        check("hazard_issue_pc", o_pc, 32'h200);
        check("hazard_rd_x0", 32'(o_hazard), 32'd0);
        cyc(); idle();
        @(negedge clk);
        check("x0_no_interlock_pc", o_pc, 32'h204);

        // writeback forwarding
        cyc(); i_rd_wr = 1; i_rd_addr = 3; i_rd_data = 32'h1111_1111;
        cyc(); i_rd_data = 32'hDEAD_BEEF; push(32'h300, 32'h0001_8033);
        cyc(); i_valid = 0; i_stall = 1; i_rd_data = 32'h1234_5678;
        @(negedge clk);
        check("bypass_on", o_rs1_data, 32'hDEAD_BEEF);
        check("bypass_off", nb_rs1_data, 32'h1111_1111);
        cyc(); idle();
        @(negedge clk);
        check("held_update", o_rs1_data, 32'h1234_5678);
        check("held_update_nb", nb_rs1_data, 32'h1234_5678);
        cyc(); i_rd_wr = 1; i_rd_addr = 0; i_rd_data = 32'hFFFF_FFFF;
        push(32'h304, 32'h0000_0033);
        cyc(); idle();
        @(negedge clk);
        check("x0_pc", o_pc, 32'h304);
        check("x0_rs1", o_rs1_data, 32'd0);
        check("x0_rs1_nb", nb_rs1_data, 32'd0);

        // flush with concurrent push
        for (int k = 0; k < 4; k++) begin
            cyc(); i_stall = 1; push(32'h400 + 32'(4 * k), 32'h13);
        end
        cyc(); i_flush = 1; push(32'h410, 32'h13);
        cyc(); idle();
        @(negedge clk);
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_ready", 32'(o_ready), 32'd1);
        cyc();
        @(negedge clk);
        check("flush_dropped", 32'(o_valid), 32'd0);

        // randomized traffic
        pc_ctr = 32'h1000;
        for (int c = 0; c < 4000; c++) begin
            cyc();
            ins = $urandom;
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            pc_ctr = pc_ctr + 32'd4;
            rst = ($urandom_range(0, 199) == 0);
            i_valid = ($urandom_range(0, 9) < 7);
            i_pc = pc_ctr;
            i_inst = ins;
            i_stall = ($urandom_range(0, 9) < 3);
            i_flush = ($urandom_range(0, 99) < 3);
            i_ex_load = ($urandom_range(0, 3) == 0);
            i_ex_rd_addr = 5'($urandom_range(0, 7));
            i_rd_wr = ($urandom_range(0, 1) == 1);
            i_rd_addr = 5'($urandom_range(0, 7));
            i_rd_data = $urandom;
        end
        cyc(); rst = 0; idle();
        for (int t = 0; t < 200 && (exp_q.size() != 0 || o_valid); t++) cyc();
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(o_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/idu_buffered.md
IDU_BUFFERED -- requirements
Module: idu_buffered

Interface
REQ-001 Parameter DEPTH, default 4, instruction queue entries; power of two, 2..16.
REQ-002 Parameter BYPASS, default 1; 1 forwards a same-cycle register writeback to read data, 0 disables forwarding.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 i_pc  in  32  fetch PC; i_inst  in  32  fetched instruction; i_valid  in  1  fetch word valid.
REQ-006 o_ready  out  1  queue can accept a word this cycle.
REQ-007 i_flush  in  1  branch/jump redirect; discard all buffered and held instructions.
REQ-008 i_stall  in  1  downstream stage holds the output register.
REQ-009 i_ex_load  in  1  EX-stage instruction is a load; i_ex_rd_addr  in  5  its destination.
REQ-010 i_rd_wr  in  1, i_rd_addr  in  5, i_rd_data  in  32  writeback port.
REQ-011 o_valid  out  1; o_pc  out  32; o_inst  out  32  registered decode-stage instruction.
REQ-012 o_rs1_addr, o_rs2_addr, o_rd_addr  out  5 each  inst[19:15], inst[24:20], inst[11:7] of o_inst.
REQ-013 o_rs1_data, o_rs2_data  out  32 each  operand values aligned with o_inst.
REQ-014 o_hazard  out  1  load-use interlock active this cycle.

Function
REQ-015 Queue: circular FIFO; push when i_valid && o_ready && !i_flush; o_ready = (count < DEPTH) && !rst; count width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-016 Output register advances when !o_valid || !i_stall; otherwise all o_* hold.
REQ-017 On advance with a queue head available and no hazard: pop head into the output register, o_valid=1 next cycle.
REQ-018 On advance with empty queue and an accepted push: the incoming word loads directly into the output register (1-cycle latency), not into the queue.
REQ-019 On advance with nothing available or hazard: o_valid=0 next cycle (bubble).
REQ-020 Hazard: i_ex_load && i_ex_rd_addr!=0 && (i_ex_rd_addr==candidate rs1 || ==candidate rs2); fields checked unconditionally regardless of format; candidate is head or bypassed word.
REQ-021 Register file 32x32, x0 reads 0, writes to x0 ignored; operands read on load into output register.
REQ-022 BYPASS=1: same-cycle i_rd_wr to a nonzero matching rs supplies i_rd_data instead of the array value.
REQ-023 While output held, a writeback to a nonzero matching o_rs1_addr/o_rs2_addr updates o_rs1_data/o_rs2_data (independent of BYPASS).
REQ-024 Push and pop in one cycle leave count unchanged; full queue with pop accepts no push that cycle (o_ready from registered count).
REQ-025 i_flush: next cycle count=0, pointers=0, o_valid=0; flush overrides push, pop and stall; register file unaffected.
REQ-026 Writeback commits to the array regardless of flush or stall.

Reset
REQ-027 While rst high at an edge: count, pointers, o_valid, o_pc, o_inst, o_rs*_data, all 32 registers set to 0.
REQ-028 o_ready=0 and o_hazard=0 while rst high; o_ready=1 first cycle after release.
REQ-029 Reset mid-operation discards queue and held instruction, same as flush plus register clear.

Structure
REQ-030 Shared package holds DEPTH default, field-slice constants (RS1_LSB=15, RS2_LSB=20, RD_LSB=7) and queue-entry struct {pc, inst}.
REQ-031 One sub-module: inst_queue (FIFO with push/pop/flush, count, head outputs); register file and output register stay in idu_buffered.

Verification
REQ-032 Reset, then push 0x00500093 at PC 0x0 into empty queue with i_stall=0 -> o_valid=1 next cycle, o_pc=0x0, o_rd_addr=1.
REQ-033 i_stall=1, push DEPTH=4 words -> o_ready=0 after 4th accepted word; 5th word not stored; release stall -> words emerge in order, one per cycle.
REQ-034 i_ex_load=1, i_ex_rd_addr=5, head rs1=5 -> o_hazard=1, o_valid=0 next cycle; drop i_ex_load -> instruction issues next cycle.
REQ-035 Head reads x3 while i_rd_wr=1, i_rd_addr=3, i_rd_data=0xDEADBEEF -> o_rs1_data=0xDEADBEEF with BYPASS=1, old value with BYPASS=0; write to x0 -> reads 0.
REQ-036 Queue holding 3 words, i_flush with concurrent push -> next cycle o_valid=0, count=0, pushed word dropped.
